// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed byte stream into 16-bit words, writes them from
// address 0 upward, verifies an 8-bit additive checksum and then releases the CPU core.
//
// state     | meaning
// ----------+----------------------------------------------------------
// CNT_HI    | waiting for high byte of word count
// CNT_LO    | waiting for low byte of word count, validates length
// DATA_HI   | waiting for high byte of current word
// DATA_LO   | waiting for low byte of current word
// WRITE     | one-cycle memory write strobe, advances word index
// CHECK     | waiting for checksum byte
// DONE      | image loaded and verified, CPU released
// ERROR     | bad length or checksum, CPU held in reset
module program_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic              restart,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              mem_write,
    output logic              cpu_reset_n,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t          state;
    logic [7:0]      cnt_hi;
    logic [ADDR_W:0] n_words;
    logic [ADDR_W:0] idx;
    logic [ADDR_W:0] idx_inc;
    logic [7:0]      sum;
    logic [15:0]     wdata;
    logic [15:0]     count_in;
    logic            xfer;

    assign count_in = {cnt_hi, in_byte};
    assign idx_inc  = idx + 1'b1;
    assign xfer     = in_valid && in_ready;

    // Every output is decoded from registered state only; nothing depends on in_valid.
    assign in_ready    = (state == S_CNT_HI) || (state == S_CNT_LO) || (state == S_DATA_HI) ||
                         (state == S_DATA_LO) || (state == S_CHECK);
    assign mem_write   = (state == S_WRITE);
    assign mem_addr    = idx[ADDR_W-1:0];
    assign mem_wdata   = wdata;
    assign done        = (state == S_DONE);
    assign error       = (state == S_ERROR);
    assign cpu_reset_n = (state == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_CNT_HI;
            cnt_hi  <= '0;
            n_words <= '0;
            idx     <= '0;
            sum     <= '0;
            wdata   <= '0;
        end else begin
            case (state)
                S_CNT_HI: begin
                    if (xfer) begin
                        cnt_hi <= in_byte;
                        state  <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (xfer) begin
                        if ((count_in == 16'd0) || ({1'b0, count_in} > MAX_LEN)) begin
                            state <= S_ERROR;
                        end else begin
                            n_words <= count_in[ADDR_W:0];
                            idx     <= '0;
                            sum     <= '0;
                            state   <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: begin
                    if (xfer) begin
                        wdata[15:8] <= in_byte;
                        sum         <= sum + in_byte;
                        state       <= S_DATA_LO;
                    end
                end
                S_DATA_LO: begin
                    if (xfer) begin
                        wdata[7:0] <= in_byte;
                        sum        <= sum + in_byte;
                        state      <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    // Index is one bit wider than the address so a full 1024-word image terminates.
                    idx   <= idx_inc;
                    state <= (idx_inc == n_words) ? S_CHECK : S_DATA_HI;
                end
                S_CHECK: begin
                    if (xfer) begin
                        state <= (in_byte == sum) ? S_DONE : S_ERROR;
                    end
                end
                S_DONE: begin
                    if (restart) state <= S_CNT_HI;
                end
                S_ERROR: begin
                    if (restart) state <= S_CNT_HI;
                end
                default: state <= S_CNT_HI;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: scoreboard of expected memory writes plus
// per-scenario checks of handshake, status and CPU release behaviour.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        restart = 1'b0;
    logic        in_ready;
    logic [9:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_write;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int wr_count = 0;
    logic [9:0]  last_addr = '0;
    logic [9:0]  exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    int          wr_cyc_q[$];
    logic [15:0] img[$];
    logic [9:0]  mon_ea;
    logic [15:0] mon_ed;

    program_loader dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_byte(in_byte),
        .in_ready(in_ready),
        .restart(restart),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_write(mem_write),
        .cpu_reset_n(cpu_reset_n),
        .done(done),
        .error(error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the next expected (address, data) in order.
    always @(negedge clk) begin
        if (reset) begin
            n_checks++;
            if (done && error) begin
                n_fail++;
                $display("FAIL done_error_exclusive: done=%b error=%b, required not both 1", done, error);
            end
        end
        if (mem_write) begin
            wr_count++;
            last_addr = mem_addr;
            wr_cyc_q.push_back(cyc);
            n_checks++;
            if (exp_addr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr=%03h data=%04h, required no write", mem_addr, mem_wdata);
            end else begin
                mon_ea = exp_addr_q.pop_front();
                mon_ed = exp_data_q.pop_front();
                if (mem_addr !== mon_ea || mem_wdata !== mon_ed) begin
                    n_fail++;
                    $display("FAIL write_scoreboard: got addr=%03h data=%04h, required addr=%03h data=%04h",
                             mem_addr, mem_wdata, mon_ea, mon_ed);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 200; k++) begin
            if (in_ready === 1'b1) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: in_ready=0 for 200 cycles on byte %02h, required 1", b);
        in_valid = 1'b0;
    endtask

    // Sends the words in img with their length prefix; stop_after >= 0 aborts after that many data bytes.
    task automatic load_image(input logic [7:0] chk_delta, input int max_gap, input int stop_after);
        logic [15:0] n;
        logic [7:0]  s;
        int          sent;
        n    = 16'(img.size());
        s    = 8'h00;
        sent = 0;
        send_byte(n[15:8], 0);
        send_byte(n[7:0], 0);
        for (int i = 0; i < img.size(); i++) begin
            send_byte(img[i][15:8], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            s = s + img[i][15:8];
            sent++;
            if (stop_after >= 0 && sent == stop_after) return;
            send_byte(img[i][7:0], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
            s = s + img[i][7:0];
            sent++;
            exp_addr_q.push_back(10'(i));
            exp_data_q.push_back(img[i]);
            if (stop_after >= 0 && sent == stop_after) return;
        end
        send_byte(s + chk_delta, 0);
    endtask

    task automatic pulse_restart();
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1 restart = 1'b0;
    endtask

    task automatic set_nominal();
        img.delete();
        img.push_back(16'h1234);
        img.push_back(16'hABCD);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (mem_write !== 1'b0)   begin n_fail++; $display("FAIL reset_mem_write: got %b, required 0", mem_write); end
        n_checks++; if (mem_addr !== 10'h000) begin n_fail++; $display("FAIL reset_mem_addr: got %03h, required 000", mem_addr); end
        n_checks++; if (mem_wdata !== 16'h0)  begin n_fail++; $display("FAIL reset_mem_wdata: got %04h, required 0000", mem_wdata); end
        n_checks++; if (cpu_reset_n !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_reset_n: got %b, required 0", cpu_reset_n); end
        n_checks++; if (done !== 1'b0)        begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
        n_checks++; if (error !== 1'b0)       begin n_fail++; $display("FAIL reset_error: got %b, required 0", error); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL idle_stall_ready: got %b, required 1", in_ready); end
    endtask

    task automatic test_nominal();
        set_nominal();
        wr_cyc_q.delete();
        load_image(8'h00, 0, -1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1)        begin n_fail++; $display("FAIL nominal_done: got %b, required 1", done); end
        n_checks++; if (cpu_reset_n !== 1'b1) begin n_fail++; $display("FAIL nominal_cpu_reset_n: got %b, required 1", cpu_reset_n); end
        n_checks++; if (error !== 1'b0)       begin n_fail++; $display("FAIL nominal_error: got %b, required 0", error); end
        n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL nominal_in_ready: got %b, required 0", in_ready); end
        n_checks++;
        if (wr_cyc_q.size() != 2) begin
            n_fail++; $display("FAIL nominal_write_count: got %0d, required 2", wr_cyc_q.size());
        end else if (wr_cyc_q[1] - wr_cyc_q[0] != 3) begin
            n_fail++; $display("FAIL nominal_write_spacing: got %0d cycles, required 3", wr_cyc_q[1] - wr_cyc_q[0]);
        end
        in_valid = 1'b1;
        in_byte  = 8'h55;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        n_checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1) begin n_fail++; $display("FAIL done_hold: done=%b cpu_reset_n=%b, required 1 1", done, cpu_reset_n); end
    endtask

    task automatic test_bad_checksum();
        pulse_restart();
        n_checks++; if (done !== 1'b0 || cpu_reset_n !== 1'b0) begin n_fail++; $display("FAIL restart_from_done: done=%b cpu_reset_n=%b, required 0 0", done, cpu_reset_n); end
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL restart_ready: got %b, required 1", in_ready); end
        set_nominal();
        load_image(8'h01, 0, -1);
        @(negedge clk);
        n_checks++; if (error !== 1'b1)       begin n_fail++; $display("FAIL badchk_error: got %b, required 1", error); end
        n_checks++; if (cpu_reset_n !== 1'b0) begin n_fail++; $display("FAIL badchk_cpu_reset_n: got %b, required 0", cpu_reset_n); end
        n_checks++; if (in_ready !== 1'b0)    begin n_fail++; $display("FAIL badchk_in_ready: got %b, required 0", in_ready); end
        n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL badchk_writes: %0d pending, required 0", exp_addr_q.size()); end
    endtask

    task automatic test_restart();
        pulse_restart();
        n_checks++; if (error !== 1'b0)    begin n_fail++; $display("FAIL restart_error_clear: got %b, required 0", error); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL restart_cnt_hi: in_ready=%b, required 1", in_ready); end
        set_nominal();
        load_image(8'h00, 0, -1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1) begin n_fail++; $display("FAIL restart_load: done=%b cpu_reset_n=%b, required 1 1", done, cpu_reset_n); end
    endtask

    task automatic test_length();
        int wr_before;
        pulse_restart();
        wr_before = wr_count;
        send_byte(8'h00, 0);
        @(negedge clk);
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL len0_early_error: got %b, required 0", error); end
        send_byte(8'h00, 0);
        @(negedge clk);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len0_error: got %b, required 1", error); end
        pulse_restart();
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL len1025_error: got %b, required 1", error); end
        n_checks++; if (cpu_reset_n !== 1'b0) begin n_fail++; $display("FAIL len1025_cpu_reset_n: got %b, required 0", cpu_reset_n); end
        n_checks++; if (wr_count != wr_before) begin n_fail++; $display("FAIL len_no_write: got %0d writes, required 0", wr_count - wr_before); end
    endtask

    task automatic test_full_backpressure();
        int wr_before;
        pulse_restart();
        img.delete();
        for (int i = 0; i < 1024; i++) img.push_back(16'(i));
        wr_before = wr_count;
        load_image(8'h00, 3, -1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL full_done: got %b, required 1", done); end
        n_checks++; if (wr_count - wr_before != 1024) begin n_fail++; $display("FAIL full_write_count: got %0d, required 1024", wr_count - wr_before); end
        n_checks++; if (last_addr !== 10'h3FF) begin n_fail++; $display("FAIL full_last_addr: got %03h, required 3ff", last_addr); end
        n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL full_pending: %0d writes missing, required 0", exp_addr_q.size()); end
    endtask

    task automatic test_reset_midload();
        pulse_restart();
        set_nominal();
        load_image(8'h00, 0, 3);
        #1 reset = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL midrst_in_ready: got %b, required 1", in_ready); end
        n_checks++; if (mem_write !== 1'b0)   begin n_fail++; $display("FAIL midrst_mem_write: got %b, required 0", mem_write); end
        n_checks++; if (mem_addr !== 10'h000 || mem_wdata !== 16'h0) begin n_fail++; $display("FAIL midrst_mem_bus: addr=%03h data=%04h, required 000 0000", mem_addr, mem_wdata); end
        n_checks++; if (cpu_reset_n !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL midrst_status: cpu_reset_n=%b done=%b error=%b, required 0 0 0", cpu_reset_n, done, error); end
        n_checks++; if (exp_addr_q.size() != 0) begin n_fail++; $display("FAIL midrst_pending: %0d, required 0", exp_addr_q.size()); end
        @(negedge clk);
        reset = 1'b1;
        load_image(8'h00, 0, -1);
        @(negedge clk);
        n_checks++; if (done !== 1'b1 || cpu_reset_n !== 1'b1) begin n_fail++; $display("FAIL midrst_reload: done=%b cpu_reset_n=%b, required 1 1", done, cpu_reset_n); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_checksum();
        test_restart();
        test_length();
        test_full_backpressure();
        test_reset_midload();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
